// File: rtl/fetch_sequencer_if.sv
// Bundle of the program-store write port, the program-counter link and the
// execute-stage handshake around the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              Start;
  logic [3:0]        PC;
  logic              ProgWe;
  logic [3:0]        ProgAddr;
  logic [DATA_W-1:0] ProgData;
  logic              InstrReady;
  logic              EnableCount;
  logic              ClearCounter;
  logic [DATA_W-1:0] Instr;
  logic              InstrValid;
  logic              Busy;
  logic              Halted;

  // master: the sequencer itself; slave: counter, loader and execute stage.
  modport master (
    input  Start, PC, ProgWe, ProgAddr, ProgData, InstrReady,
    output EnableCount, ClearCounter, Instr, InstrValid, Busy, Halted
  );

  modport slave (
    output Start, PC, ProgWe, ProgAddr, ProgData, InstrReady,
    input  EnableCount, ClearCounter, Instr, InstrValid, Busy, Halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads a 16-word program store at the external
// PC, issues each word over valid/ready and steps the counter once per word.
module fetch_sequencer #(
  parameter int         DATA_W    = 8,
  parameter logic [3:0] HALT_OP   = 4'hF,
  parameter bit         WRAP_HALT = 1'b1
) (
  input logic               MainClock,
  input logic               ClearN,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, CLR, FETCH, ISSUE, STEP, HALT
  } stateT;

  stateT             state, stateNext;
  logic [DATA_W-1:0] store [16];
  logic [DATA_W-1:0] instrQ;
  logic              enableCountQ, clearCounterQ, instrValidQ, busyQ, haltedQ;
  logic              progOpen;
  logic [3:0]        opcode;

  assign progOpen = (state == IDLE) || (state == HALT);
  assign opcode   = instrQ[DATA_W-1 -: 4];

  // NOTE: the store must read as all-NOP after reset, so it is a resettable
  // register array rather than a RAM macro that would power up undefined.
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) begin
      for (int i = 0; i < 16; i++) store[i] <= '0;
    end else if (bus.ProgWe && progOpen) begin
      store[bus.ProgAddr] <= bus.ProgData;
    end
  end

  // NOTE: every variable assigned here gets its default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (bus.Start) stateNext = CLR;
      CLR:   stateNext = FETCH;
      FETCH: stateNext = ISSUE;
      ISSUE: begin
        if (bus.InstrReady) begin
          if (opcode == HALT_OP)                  stateNext = HALT;
          else if (bus.PC == 4'hF && WRAP_HALT)   stateNext = HALT;
          else                                    stateNext = STEP;
        end
      end
      STEP:  stateNext = FETCH;
      HALT:  if (bus.Start) stateNext = CLR;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state, so the counter strobes
  // never see decode glitches from a multi-bit state transition.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) begin
      state         <= IDLE;
      instrQ        <= '0;
      enableCountQ  <= 1'b0;
      clearCounterQ <= 1'b0;
      instrValidQ   <= 1'b0;
      busyQ         <= 1'b0;
      haltedQ       <= 1'b0;
    end else begin
      state         <= stateNext;
      enableCountQ  <= (stateNext == STEP);
      clearCounterQ <= (stateNext == CLR);
      instrValidQ   <= (stateNext == ISSUE);
      busyQ         <= (stateNext == CLR) || (stateNext == FETCH) ||
                       (stateNext == ISSUE) || (stateNext == STEP);
      haltedQ       <= (stateNext == HALT);
      if (state == FETCH) instrQ <= store[bus.PC];
    end
  end

  assign bus.EnableCount  = enableCountQ;
  assign bus.ClearCounter = clearCounterQ;
  assign bus.Instr        = instrQ;
  assign bus.InstrValid   = instrValidQ;
  assign bus.Busy         = busyQ;
  assign bus.Halted       = haltedQ;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: two instances (halt-at-15 and
// wrap-around), each with a behavioural 4-bit program counter and a scoreboard.
module tb_fetch_sequencer;
  localparam int DATA_W = 8;

  logic MainClock = 1'b0;
  logic ClearN    = 1'b0;
  always #5 MainClock = ~MainClock;

  fetch_sequencer_if #(.DATA_W(DATA_W)) bus  ();
  fetch_sequencer_if #(.DATA_W(DATA_W)) busW ();

  fetch_sequencer #(.DATA_W(DATA_W), .HALT_OP(4'hF), .WRAP_HALT(1'b1)) dut (
    .MainClock(MainClock), .ClearN(ClearN), .bus(bus)
  );
  fetch_sequencer #(.DATA_W(DATA_W), .HALT_OP(4'hF), .WRAP_HALT(1'b0)) dutW (
    .MainClock(MainClock), .ClearN(ClearN), .bus(busW)
  );

  // Program-counter models driven by the sequencer strobes.
  logic [3:0] pcModel, pcModelW;
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN)               pcModel <= 4'd0;
    else if (bus.ClearCounter) pcModel <= 4'd0;
    else if (bus.EnableCount)  pcModel <= pcModel + 4'd1;
  end
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN)                pcModelW <= 4'd0;
    else if (busW.ClearCounter) pcModelW <= 4'd0;
    else if (busW.EnableCount)  pcModelW <= pcModelW + 4'd1;
  end
  assign bus.PC  = pcModel;
  assign busW.PC = pcModelW;

  int testsRun = 0;
  int failures = 0;
  int enCnt, clrCnt, hsCnt, hsCntW;
  logic [DATA_W-1:0] expQ[$];
  logic [DATA_W-1:0] expQW[$];
  logic [DATA_W-1:0] expMon, expMonW;

  // Scoreboard monitors: sample mid-cycle, one pop per handshake.
  always @(negedge MainClock) begin
    if (ClearN) begin
      if (bus.EnableCount)  enCnt++;
      if (bus.ClearCounter) clrCnt++;
      if (bus.InstrValid && bus.InstrReady) begin
        hsCnt++;
        testsRun++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL hs_unexpected: Instr=%h accepted, required no handshake", bus.Instr);
        end else begin
          expMon = expQ.pop_front();
          if (bus.Instr !== expMon) begin
            failures++;
            $display("FAIL hs_instr: got %h, required %h", bus.Instr, expMon);
          end
        end
      end
    end
  end

  always @(negedge MainClock) begin
    if (ClearN && busW.InstrValid && busW.InstrReady) begin
      hsCntW++;
      testsRun++;
      if (expQW.size() == 0) begin
        failures++;
        $display("FAIL hsW_unexpected: Instr=%h accepted, required no handshake", busW.Instr);
      end else begin
        expMonW = expQW.pop_front();
        if (busW.Instr !== expMonW) begin
          failures++;
          $display("FAIL hsW_instr: got %h, required %h", busW.Instr, expMonW);
        end
      end
    end
  end

  task automatic step();
    @(posedge MainClock);
    #1;
  endtask

  task automatic clearCounts();
    enCnt = 0; clrCnt = 0; hsCnt = 0;
  endtask

  task automatic writeWord(input logic [3:0] a, input logic [DATA_W-1:0] d);
    bus.ProgWe = 1'b1; bus.ProgAddr = a; bus.ProgData = d;
    step();
    bus.ProgWe = 1'b0;
  endtask

  task automatic startPulse();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
  endtask

  task automatic waitHalted(input string name, input int budget);
    int n = 0;
    while (!bus.Halted && n < budget) begin
      step();
      n++;
    end
    testsRun++;
    if (bus.Halted !== 1'b1) begin
      failures++;
      $display("FAIL %s_halt_timeout: Halted=%b after %0d cycles, required 1", name, bus.Halted, n);
    end
  endtask

  task automatic test_reset();
    bus.Start = 0; bus.ProgWe = 0; bus.ProgAddr = 0; bus.ProgData = 0; bus.InstrReady = 0;
    busW.Start = 0; busW.ProgWe = 0; busW.ProgAddr = 0; busW.ProgData = 0; busW.InstrReady = 0;
    ClearN = 1'b0;
    step(); step();
    testsRun++;
    if ({bus.EnableCount, bus.ClearCounter, bus.InstrValid, bus.Busy, bus.Halted} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b, required 00000",
               {bus.EnableCount, bus.ClearCounter, bus.InstrValid, bus.Busy, bus.Halted});
    end
    testsRun++;
    if (bus.Instr !== '0) begin
      failures++;
      $display("FAIL reset_instr: got %h, required 00", bus.Instr);
    end
    ClearN = 1'b1;
    step(); step();
    testsRun++;
    if ({busW.EnableCount, busW.ClearCounter, busW.InstrValid, busW.Busy, busW.Halted, bus.Busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_idle_hold: got %b, required 000000",
               {busW.EnableCount, busW.ClearCounter, busW.InstrValid, busW.Busy, busW.Halted, bus.Busy});
    end
  endtask

  task automatic test_basic_run();
    writeWord(4'd0, 8'h11);
    writeWord(4'd1, 8'h22);
    writeWord(4'd2, 8'hF0);
    clearCounts();
    expQ.push_back(8'h11); expQ.push_back(8'h22); expQ.push_back(8'hF0);
    bus.InstrReady = 1'b1;
    startPulse();
    waitHalted("basic", 60);
    testsRun++;
    if (clrCnt !== 1 || enCnt !== 2 || hsCnt !== 3) begin
      failures++;
      $display("FAIL basic_counts: clr=%0d en=%0d hs=%0d, required 1 2 3", clrCnt, enCnt, hsCnt);
    end
    testsRun++;
    if (bus.Instr !== 8'hF0 || pcModel !== 4'd2 || expQ.size() != 0) begin
      failures++;
      $display("FAIL basic_final: Instr=%h pc=%0d left=%0d, required F0 2 0", bus.Instr, pcModel, expQ.size());
    end
  endtask

  task automatic test_backpressure();
    clearCounts();
    bus.InstrReady = 1'b0;
    expQ.push_back(8'h11); expQ.push_back(8'h22); expQ.push_back(8'hF0);
    startPulse();
    step(); step();
    testsRun++;
    if (bus.InstrValid !== 1'b1 || bus.Instr !== 8'h11) begin
      failures++;
      $display("FAIL bp_first_issue: valid=%b Instr=%h, required 1 11", bus.InstrValid, bus.Instr);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      testsRun++;
      if (bus.InstrValid !== 1'b1 || bus.Instr !== 8'h11 || bus.EnableCount !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b Instr=%h en=%b, required 1 11 0",
                 i, bus.InstrValid, bus.Instr, bus.EnableCount);
      end
    end
    bus.InstrReady = 1'b1;
    step();
    testsRun++;
    if (bus.EnableCount !== 1'b1 || bus.InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL bp_step: en=%b valid=%b, required 1 0", bus.EnableCount, bus.InstrValid);
    end
    waitHalted("bp", 60);
    testsRun++;
    if (enCnt !== 2 || hsCnt !== 3) begin
      failures++;
      $display("FAIL bp_counts: en=%0d hs=%0d, required 2 3", enCnt, hsCnt);
    end
  endtask

  task automatic test_wrap();
    int n;
    for (int i = 0; i < 16; i++) writeWord(4'(i), 8'h00);
    clearCounts();
    for (int i = 0; i < 16; i++) expQ.push_back(8'h00);
    bus.InstrReady = 1'b1;
    startPulse();
    waitHalted("wrap_halt", 100);
    testsRun++;
    if (hsCnt !== 16 || enCnt !== 15 || pcModel !== 4'd15 || expQ.size() != 0) begin
      failures++;
      $display("FAIL wrap_halt_counts: hs=%0d en=%0d pc=%0d left=%0d, required 16 15 15 0",
               hsCnt, enCnt, pcModel, expQ.size());
    end
    // Wrap-around instance: store[0] is marked so the 17th fetch is recognisable.
    busW.ProgWe = 1'b1; busW.ProgAddr = 4'd0; busW.ProgData = 8'h3C;
    step();
    busW.ProgWe = 1'b0;
    hsCntW = 0;
    expQW.push_back(8'h3C);
    for (int i = 0; i < 15; i++) expQW.push_back(8'h00);
    expQW.push_back(8'h3C);
    busW.InstrReady = 1'b1;
    busW.Start = 1'b1;
    step();
    busW.Start = 1'b0;
    n = 0;
    while (hsCntW < 17 && n < 200) begin
      step();
      n++;
    end
    busW.InstrReady = 1'b0;
    testsRun++;
    if (hsCntW !== 17 || expQW.size() != 0 || busW.Halted !== 1'b0) begin
      failures++;
      $display("FAIL wrap_cont: hs=%0d left=%0d halted=%b, required 17 0 0", hsCntW, expQW.size(), busW.Halted);
    end
    step(); step(); step();
    testsRun++;
    if (busW.InstrValid !== 1'b1 || pcModelW !== 4'd1) begin
      failures++;
      $display("FAIL wrap_next: valid=%b pc=%0d, required 1 1", busW.InstrValid, pcModelW);
    end
  endtask

  task automatic test_store_write();
    writeWord(4'd0, 8'h01);
    writeWord(4'd1, 8'h02);
    writeWord(4'd2, 8'h03);
    writeWord(4'd3, 8'hF4);
    clearCounts();
    expQ.push_back(8'h01); expQ.push_back(8'h02); expQ.push_back(8'h03); expQ.push_back(8'hF4);
    bus.InstrReady = 1'b1;
    startPulse();
    step(); step();
    testsRun++;
    if (bus.Busy !== 1'b1) begin
      failures++;
      $display("FAIL sw_busy: Busy=%b, required 1", bus.Busy);
    end
    writeWord(4'd3, 8'hEE);
    waitHalted("sw_busy_write", 60);
    testsRun++;
    if (bus.Instr !== 8'hF4 || hsCnt !== 4) begin
      failures++;
      $display("FAIL sw_ignored: Instr=%h hs=%0d, required F4 4", bus.Instr, hsCnt);
    end
    expQ.push_back(8'h5A); expQ.push_back(8'h02); expQ.push_back(8'h03); expQ.push_back(8'hF4);
    bus.ProgWe = 1'b1; bus.ProgAddr = 4'd0; bus.ProgData = 8'h5A; bus.Start = 1'b1;
    step();
    bus.ProgWe = 1'b0; bus.Start = 1'b0;
    waitHalted("sw_with_start", 60);
    testsRun++;
    if (hsCnt !== 8 || expQ.size() != 0) begin
      failures++;
      $display("FAIL sw_start_counts: hs=%0d left=%0d, required 8 0", hsCnt, expQ.size());
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    clearCounts();
    expQ.push_back(8'h5A);
    bus.InstrReady = 1'b1;
    startPulse();
    while (bus.EnableCount !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    testsRun++;
    if (bus.EnableCount !== 1'b1) begin
      failures++;
      $display("FAIL rm_reach_step: EnableCount=%b after %0d cycles, required 1", bus.EnableCount, n);
    end
    #2 ClearN = 1'b0;
    #1;
    testsRun++;
    if ({bus.EnableCount, bus.ClearCounter, bus.InstrValid, bus.Busy, bus.Halted} !== 5'b0 ||
        bus.Instr !== '0 || busW.Busy !== 1'b0) begin
      failures++;
      $display("FAIL rm_async_clear: flags=%b Instr=%h busyW=%b, required 00000 00 0",
               {bus.EnableCount, bus.ClearCounter, bus.InstrValid, bus.Busy, bus.Halted}, bus.Instr, busW.Busy);
    end
    step();
    ClearN = 1'b1;
    step();
    testsRun++;
    if (expQ.size() != 0 || bus.Busy !== 1'b0 || bus.Halted !== 1'b0) begin
      failures++;
      $display("FAIL rm_idle: left=%0d busy=%b halted=%b, required 0 0 0", expQ.size(), bus.Busy, bus.Halted);
    end
    clearCounts();
    for (int i = 0; i < 16; i++) expQ.push_back(8'h00);
    startPulse();
    waitHalted("rm_rerun", 100);
    testsRun++;
    if (hsCnt !== 16 || expQ.size() != 0) begin
      failures++;
      $display("FAIL rm_rerun_counts: hs=%0d left=%0d, required 16 0", hsCnt, expQ.size());
    end
  endtask

  task automatic test_restart();
    writeWord(4'd0, 8'h07);
    writeWord(4'd1, 8'hF8);
    clearCounts();
    bus.InstrReady = 1'b0;
    expQ.push_back(8'h07); expQ.push_back(8'hF8);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    testsRun++;
    if (bus.ClearCounter !== 1'b1 || bus.InstrValid !== 1'b0 || bus.Halted !== 1'b0) begin
      failures++;
      $display("FAIL rs_clr: clr=%b valid=%b halted=%b, required 1 0 0", bus.ClearCounter, bus.InstrValid, bus.Halted);
    end
    step();
    bus.Start = 1'b1;
    testsRun++;
    if (bus.InstrValid !== 1'b0 || bus.Busy !== 1'b1 || bus.ClearCounter !== 1'b0) begin
      failures++;
      $display("FAIL rs_fetch: valid=%b busy=%b clr=%b, required 0 1 0", bus.InstrValid, bus.Busy, bus.ClearCounter);
    end
    step();
    bus.Start = 1'b0;
    testsRun++;
    if (bus.InstrValid !== 1'b1 || bus.Instr !== 8'h07) begin
      failures++;
      $display("FAIL rs_latency: valid=%b Instr=%h, required 1 07", bus.InstrValid, bus.Instr);
    end
    bus.InstrReady = 1'b1;
    waitHalted("rs", 40);
    testsRun++;
    if (clrCnt !== 1 || hsCnt !== 2 || enCnt !== 1) begin
      failures++;
      $display("FAIL rs_counts: clr=%0d hs=%0d en=%0d, required 1 2 1", clrCnt, hsCnt, enCnt);
    end
  endtask

  initial begin
    clearCounts();
    hsCntW = 0;
    test_reset();
    test_basic_run();
    test_backpressure();
    test_wrap();
    test_store_write();
    test_reset_midrun();
    test_restart();
    step(); step();
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
